// File: rtl/uart_tx.sv
// uart_tx: 8N1 asynchronous serial transmitter with optional even parity.
// Accepts a byte on a Start pulse while idle, shifts it out LSB-first on TxD,
// and pulses Done for one cycle when the stop bit completes.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] data_in,
  output logic       TxD,
  output logic       Busy,
  output logic       Done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP_BIT
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q,   par_d;
  logic          txd_q,   txd_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state logic. TxD/Busy/Done are registered, so each transition also
  // computes the line level for the state being entered (e.g. shift_q[1] is
  // the next data bit because the register shifts on the same edge).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (Start) begin
          shift_d = data_in;
          par_d   = ^data_in;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START_BIT;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP_BIT;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP_BIT;
          txd_d   = 1'b1;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TxD  = txd_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: two instances (C=4 without and with parity), a
// serial-line monitor per instance that pops expected bytes from a queue.
module tb_uart_tx;

  logic       Clk;
  logic       Reset;
  logic       clk_en;
  logic       start [2];
  logic [7:0] din   [2];
  logic       txd   [2];
  logic       busy  [2];
  logic       done  [2];

  int n_vec;
  int n_err;
  int cyc;
  int dn0, dn1;
  int frames  [2];
  int aborts  [2];
  int last_e0 [2];
  int last_gap[2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .data_in(din[0]),
    .TxD(txd[0]), .Busy(busy[0]), .Done(done[0])
  );

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .data_in(din[1]),
    .TxD(txd[1]), .Busy(busy[1]), .Done(done[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = clk_en ? ~Clk : Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (done[0] === 1'b1) dn0 <= dn0 + 1;
    if (done[1] === 1'b1) dn1 <= dn1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Watches one serial line; on a start bit, pops the expected byte and
  // checks every cycle of the frame plus the Done cycle.
  task automatic mon(input int id);
    int         n;
    int         e0;
    logic [7:0] b;
    logic [10:0] fr;
    bit         ab;
    n = (id == 0) ? 40 : 44;
    forever begin
      @(negedge Clk);
      if (Reset === 1'b0 && txd[id] === 1'b0) begin
        e0 = cyc;
        b  = 8'h00;
        if (id == 0) begin
          chk("d0_queue_nonempty", 32'(q0.size() > 0), 32'd1);
          if (q0.size() > 0) b = q0.pop_front();
        end else begin
          chk("d1_queue_nonempty", 32'(q1.size() > 0), 32'd1);
          if (q1.size() > 0) b = q1.pop_front();
        end
        fr = '1;
        fr[0] = 1'b0;
        for (int k = 0; k < 8; k++) fr[k+1] = b[k];
        if (id == 1) fr[9] = ^b;
        ab = 1'b0;
        for (int j = 0; j <= n; j++) begin
          if (j > 0) @(negedge Clk);
          if (Reset === 1'b1) begin
            ab = 1'b1;
            aborts[id]++;
            break;
          end
          if (j < n) begin
            chk($sformatf("d%0d_b%02h_txd@%0d", id, b, j), 32'(txd[id]), 32'(fr[j/4]));
            chk($sformatf("d%0d_b%02h_busy@%0d", id, b, j), 32'(busy[id]), 32'd1);
            chk($sformatf("d%0d_b%02h_done@%0d", id, b, j), 32'(done[id]), 32'd0);
          end else begin
            chk($sformatf("d%0d_b%02h_txd_end", id, b), 32'(txd[id]), 32'd1);
            chk($sformatf("d%0d_b%02h_busy_end", id, b), 32'(busy[id]), 32'd0);
            chk($sformatf("d%0d_b%02h_done_end", id, b), 32'(done[id]), 32'd1);
          end
        end
        if (!ab) begin
          frames[id]++;
          last_gap[id] = e0 - last_e0[id];
          last_e0[id]  = e0;
        end
      end
    end
  endtask

  task automatic send(input int id, input logic [7:0] b);
    @(negedge Clk);
    start[id] = 1'b1;
    din[id]   = b;
    if (id == 0) q0.push_back(b); else q1.push_back(b);
    @(negedge Clk);
    start[id] = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; dn0 = 0; dn1 = 0;
    for (int i = 0; i < 2; i++) begin
      frames[i] = 0; aborts[i] = 0; last_e0[i] = 0; last_gap[i] = 0;
      start[i] = 1'b0; din[i] = 8'h00;
    end
    clk_en = 1'b0;
    Reset  = 1'b0;
    fork
      mon(0);
      mon(1);
    join_none

    // Asynchronous reset with the clock stopped
    #5 Reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_txd%0d", i), 32'(txd[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
    end
    clk_en = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // 0xA5 without parity, 0x07 with parity, in parallel
    @(negedge Clk);
    start[0] = 1'b1; din[0] = 8'hA5; q0.push_back(8'hA5);
    start[1] = 1'b1; din[1] = 8'h07; q1.push_back(8'h07);
    @(negedge Clk);
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (50) @(negedge Clk);
    chk("frames0_a5", 32'(frames[0]), 32'd1);
    chk("frames1_07", 32'(frames[1]), 32'd1);

    send(1, 8'h03);
    repeat (50) @(negedge Clk);
    chk("frames1_03", 32'(frames[1]), 32'd2);
    chk("done0_cnt1", 32'(dn0), 32'd1);
    chk("done1_cnt2", 32'(dn1), 32'd2);

    // Start while busy must be ignored
    @(negedge Clk);
    start[0] = 1'b1; din[0] = 8'h3C; q0.push_back(8'h3C);
    @(negedge Clk);
    start[0] = 1'b0;
    repeat (12) @(negedge Clk);
    start[0] = 1'b1; din[0] = 8'hFF;
    @(negedge Clk);
    start[0] = 1'b0; din[0] = 8'h00;
    repeat (60) @(negedge Clk);
    chk("frames0_3c", 32'(frames[0]), 32'd2);
    chk("done0_cnt2", 32'(dn0), 32'd2);
    chk("q0_empty_3c", 32'(q0.size()), 32'd0);

    // Back-to-back with Start held high
    @(negedge Clk);
    start[0] = 1'b1; din[0] = 8'h55; q0.push_back(8'h55);
    @(negedge Clk);
    din[0] = 8'h81; q0.push_back(8'h81);
    repeat (44) @(negedge Clk);
    start[0] = 1'b0;
    repeat (50) @(negedge Clk);
    chk("frames0_b2b", 32'(frames[0]), 32'd4);
    chk("gap0_b2b", 32'(last_gap[0]), 32'd41);
    chk("done0_cnt4", 32'(dn0), 32'd4);
    chk("q0_empty_b2b", 32'(q0.size()), 32'd0);

    // Reset mid-frame at E0+18
    @(negedge Clk);
    start[0] = 1'b1; din[0] = 8'h00; q0.push_back(8'h00);
    @(posedge Clk);
    #1 start[0] = 1'b0;
    repeat (18) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd[0]), 32'd1);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_done", 32'(done[0]), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("aborts0", 32'(aborts[0]), 32'd1);
    repeat (50) @(negedge Clk);
    chk("done0_after_abort", 32'(dn0), 32'd4);
    chk("frames0_after_abort", 32'(frames[0]), 32'd4);

    send(0, 8'h96);
    repeat (50) @(negedge Clk);
    chk("frames0_96", 32'(frames[0]), 32'd5);
    chk("done0_cnt5", 32'(dn0), 32'd5);
    chk("q0_empty_end", 32'(q0.size()), 32'd0);
    chk("q1_empty_end", 32'(q1.size()), 32'd0);
    chk("done1_final", 32'(dn1), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
